// File: rtl/alu_cmd_sequencer_if.sv
// alu_cmd_sequencer_if: command, ALU-side and response channels of the ALU sequencer
interface alu_cmd_sequencer_if #(
    parameter int WIDTH = 16,
    parameter int TAG_W = 4
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [WIDTH-1:0] cmd_a;
    logic [WIDTH-1:0] cmd_b;
    logic [2:0]       cmd_op;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [2:0]       alu_op;
    logic [WIDTH-1:0] alu_result;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_data;
    logic             rsp_err;
    logic [TAG_W-1:0] rsp_tag;

    modport slave (
        input  cmd_valid, cmd_a, cmd_b, cmd_op, alu_result, rsp_ready,
        output cmd_ready, alu_a, alu_b, alu_op, rsp_valid, rsp_data, rsp_err, rsp_tag
    );

    modport master (
        output cmd_valid, cmd_a, cmd_b, cmd_op, alu_result, rsp_ready,
        input  cmd_ready, alu_a, alu_b, alu_op, rsp_valid, rsp_data, rsp_err, rsp_tag
    );
endinterface

// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: one-at-a-time command front-end that registers ALU inputs and returns tagged results
module alu_cmd_sequencer #(
    parameter int WIDTH = 16,
    parameter int TAG_W = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    alu_cmd_sequencer_if.slave  bus
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, data_q, data_d;
    logic [2:0]       op_q, op_d;
    logic             err_q, err_d;
    logic [TAG_W-1:0] tag_q, tag_d, seq_q, seq_d;

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        data_d  = data_q;
        err_d   = err_q;
        tag_d   = tag_q;
        seq_d   = seq_q;
        if (state_q == IDLE && bus.cmd_valid) begin
            a_d     = bus.cmd_a;
            b_d     = bus.cmd_b;
            op_d    = bus.cmd_op;
            state_d = EXEC;
        end
        if (state_q == EXEC) begin
            data_d  = bus.alu_result;
            err_d   = op_q[2:1] == 2'b11;
            tag_d   = seq_q;
            state_d = RESP;
        end
        // the sequence advances only on a completed response handshake
        if (state_q == RESP && bus.rsp_ready) begin
            seq_d   = seq_q + 1'b1;
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
            tag_q   <= '0;
            seq_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            data_q  <= data_d;
            err_q   <= err_d;
            tag_q   <= tag_d;
            seq_q   <= seq_d;
        end
    end

    assign bus.cmd_ready = state_q == IDLE;
    assign bus.rsp_valid = state_q == RESP;
    assign bus.alu_a     = a_q;
    assign bus.alu_b     = b_q;
    assign bus.alu_op    = op_q;
    assign bus.rsp_data  = data_q;
    assign bus.rsp_err   = err_q;
    assign bus.rsp_tag   = tag_q;
endmodule
